// File: rtl/eeprom_28c256_ctrl.sv
// eeprom_28c256_ctrl: host byte read/write master for a 28C256 EEPROM, groups same-page writes, closes pages with DATA# polling.
// Latency: read accept->rsp_valid T_ACC+1 cycles; write rsp_valid after T_BLC idle cycles plus DQ7 poll success or T_WC_MAX timeout.
// Backpressure: req_ready only in IDLE, or in PAGE_OPEN for a write into the open page; all other requests stall until commit.
// Build option: define EE_SDP_EN to prefix each page load with the AA/55/A0 software-data-protection unlock writes.
module eeprom_28c256_ctrl #(
  parameter int T_ACC    = 4,
  parameter int T_WP     = 3,
  parameter int T_BLC    = 100,
  parameter int T_WC_MAX = 10000,
  parameter int T_POLL   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        wr_err,
  output logic [14:0] ee_addr,
  output logic [7:0]  ee_dq_o,
  output logic        ee_dq_oe,
  input  logic [7:0]  ee_dq_i,
  output logic        ee_ce_n,
  output logic        ee_oe_n,
  output logic        ee_we_n
);

  localparam int CMAX_A = (T_ACC > T_WP) ? T_ACC : T_WP;
  localparam int CMAX   = (CMAX_A > T_POLL) ? CMAX_A : T_POLL;
  localparam int CNT_W  = $clog2(CMAX + 1);
  localparam int BLC_W  = $clog2(T_BLC + 1);
  localparam int WC_W   = $clog2(T_WC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CMAX);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(T_ACC - 1);
  localparam logic [CNT_W-1:0] WP_LAST   = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(T_POLL - 1);
  localparam logic [BLC_W-1:0] BLC_MAX   = BLC_W'(T_BLC);
  localparam logic [BLC_W-1:0] BLC_LAST  = BLC_W'(T_BLC - 1);
  localparam logic [WC_W-1:0]  WC_MAX    = WC_W'(T_WC_MAX);
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(T_WC_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RSP,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_PAGE_OPEN,
    S_POLL_RD,
    S_POLL_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLC_W-1:0]  blc_q, blc_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [14:0]       addr_q, addr_d;
  logic [7:0]        dq_q, dq_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [8:0]        page_q, page_d;
  logic [14:0]       laddr_q, laddr_d;
  logic              lbit7_q, lbit7_d;
`ifdef EE_SDP_EN
  logic              sdp_act_q, sdp_act_d;
  logic [1:0]        sdp_idx_q, sdp_idx_d;
  logic [7:0]        hold_q, hold_d;
`endif

  logic page_hit;
  logic accept;
  logic poll_match;
  logic wc_expired;

  assign page_hit   = req_we && (req_addr[14:6] == page_q);
  assign req_ready  = (state_q == S_IDLE) || ((state_q == S_PAGE_OPEN) && page_hit);
  assign accept     = req_valid && req_ready;
  assign poll_match = (ee_dq_i[7] == lbit7_q);
  assign wc_expired = (wc_q >= WC_LAST);

  assign ee_addr    = addr_q;
  assign ee_dq_o    = dq_q;
  assign rsp_rdata  = rdata_q;
  assign wr_err     = err_q;

  // State register and datapath registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      blc_q     <= '0;
      wc_q      <= '0;
      addr_q    <= '0;
      dq_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      page_q    <= '0;
      laddr_q   <= '0;
      lbit7_q   <= 1'b0;
`ifdef EE_SDP_EN
      sdp_act_q <= 1'b0;
      sdp_idx_q <= '0;
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blc_q     <= blc_d;
      wc_q      <= wc_d;
      addr_q    <= addr_d;
      dq_q      <= dq_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      page_q    <= page_d;
      laddr_q   <= laddr_d;
      lbit7_q   <= lbit7_d;
`ifdef EE_SDP_EN
      sdp_act_q <= sdp_act_d;
      sdp_idx_q <= sdp_idx_d;
      hold_q    <= hold_d;
`endif
    end
  end

  // Next-state, strobe decode and request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blc_d     = blc_q;
    wc_d      = wc_q;
    addr_d    = addr_q;
    dq_d      = dq_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    page_d    = page_q;
    laddr_d   = laddr_q;
    lbit7_d   = lbit7_q;
`ifdef EE_SDP_EN
    sdp_act_d = sdp_act_q;
    sdp_idx_d = sdp_idx_q;
    hold_d    = hold_q;
`endif
    rsp_valid = 1'b0;
    ee_ce_n   = 1'b1;
    ee_oe_n   = 1'b1;
    ee_we_n   = 1'b1;
    ee_dq_oe  = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_RD: begin
        ee_ce_n = 1'b0;
        ee_oe_n = 1'b0;
        if (cnt_q == ACC_LAST) begin
          rdata_d = ee_dq_i;
          cnt_d   = '0;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_WR_SETUP: begin
        ee_ce_n  = 1'b0;
        ee_dq_oe = 1'b1;
        cnt_d    = '0;
        state_d  = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        ee_ce_n  = 1'b0;
        ee_we_n  = 1'b0;
        ee_dq_oe = 1'b1;
        if (cnt_q == WP_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        ee_ce_n  = 1'b0;
        ee_dq_oe = 1'b1;
        state_d  = S_PAGE_OPEN;
`ifdef EE_SDP_EN
        // Unlock bytes chain straight into the next load; the host byte follows the third.
        if (sdp_act_q) begin
          state_d = S_WR_SETUP;
          if (sdp_idx_q == 2'd2) begin
            sdp_act_d = 1'b0;
            addr_d    = laddr_q;
            dq_d      = hold_q;
          end else begin
            sdp_idx_d = sdp_idx_q + 2'd1;
            addr_d    = (sdp_idx_q == 2'd0) ? 15'h2AAA : 15'h5555;
            dq_d      = (sdp_idx_q == 2'd0) ? 8'h55 : 8'hA0;
          end
        end
`endif
      end
      S_PAGE_OPEN: begin
        if (blc_q != BLC_MAX) blc_d = blc_q + BLC_W'(1);
        if (!accept && (blc_q >= BLC_LAST)) begin
          addr_d  = laddr_q;
          cnt_d   = '0;
          wc_d    = '0;
          state_d = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        ee_ce_n = 1'b0;
        ee_oe_n = 1'b0;
        if (wc_q != WC_MAX) wc_d = wc_q + WC_W'(1);
        if ((cnt_q == ACC_LAST) && poll_match) begin
          state_d = S_RSP;
        end else if (wc_expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else if (cnt_q == ACC_LAST) begin
          cnt_d   = '0;
          state_d = S_POLL_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POLL_WAIT: begin
        if (wc_q != WC_MAX) wc_d = wc_q + WC_W'(1);
        if (wc_expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else if (cnt_q == POLL_LAST) begin
          cnt_d   = '0;
          state_d = S_POLL_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accepted request clears the error flag and starts its bus cycle.
    if (accept) begin
      err_d  = 1'b0;
      addr_d = req_addr;
      cnt_d  = '0;
      if (req_we) begin
        dq_d    = req_wdata;
        page_d  = req_addr[14:6];
        laddr_d = req_addr;
        lbit7_d = req_wdata[7];
        blc_d   = '0;
        state_d = S_WR_SETUP;
`ifdef EE_SDP_EN
        if (state_q == S_IDLE) begin
          hold_d    = req_wdata;
          sdp_act_d = 1'b1;
          sdp_idx_d = 2'd0;
          addr_d    = 15'h5555;
          dq_d      = 8'hAA;
        end
`endif
      end else begin
        state_d = S_RD;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_28c256_ctrl.sv
// Directed bench for eeprom_28c256_ctrl with a small behavioural 28C256 model.
// Model: byte writes land at the end of each WE# pulse; while busy, DQ7 reads back inverted.
// Define EE_SDP_EN for both files to exercise the unlock-sequence build.
module tb_eeprom_28c256_ctrl;

`ifdef EE_SDP_EN
  localparam int SDP_N = 3;
`else
  localparam int SDP_N = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        wr_err;
  logic [14:0] ee_addr;
  logic [7:0]  ee_dq_o;
  logic        ee_dq_oe;
  logic [7:0]  ee_dq_i;
  logic        ee_ce_n;
  logic        ee_oe_n;
  logic        ee_we_n;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int busy_until = 0;
  bit busy_forever = 0;
  bit [7:0] mem [0:32767];

  int viol = 0;
  int rsp_cnt = 0;
  int we_len = 0;
  int log_n = 0;
  logic [14:0] log_addr [0:63];
  logic [7:0]  log_dat  [0:63];
  int          log_len  [0:63];
  logic        prev_we_n = 1'b1;
  logic [14:0] prev_addr = '0;

  eeprom_28c256_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_err    (wr_err),
    .ee_addr   (ee_addr),
    .ee_dq_o   (ee_dq_o),
    .ee_dq_oe  (ee_dq_oe),
    .ee_dq_i   (ee_dq_i),
    .ee_ce_n   (ee_ce_n),
    .ee_oe_n   (ee_oe_n),
    .ee_we_n   (ee_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Device read path: 0x1234 is a fixed ROM byte; busy inverts DQ7 (DATA# polling).
  always_comb begin
    ee_dq_i = mem[ee_addr];
    if (ee_addr == 15'h1234) ee_dq_i = 8'h5A;
    if (busy_forever || (cyc < busy_until)) ee_dq_i[7] = ~ee_dq_i[7];
  end

  // Pin monitor: bus-rule violations, response pulses, WE# pulse log and device writes.
  always @(negedge clk) begin
    prev_we_n <= ee_we_n;
    prev_addr <= ee_addr;
    if (!ee_oe_n && ee_dq_oe) viol <= viol + 1;
    if (!ee_we_n && !prev_we_n && (ee_addr != prev_addr)) viol <= viol + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (!ee_we_n) begin
      we_len <= we_len + 1;
    end else if (!prev_we_n) begin
      if (log_n < 64) begin
        log_addr[log_n] <= ee_addr;
        log_dat[log_n]  <= ee_dq_o;
        log_len[log_n]  <= we_len;
        log_n           <= log_n + 1;
      end
      mem[ee_addr] <= ee_dq_o;
      we_len       <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted or the budget runs out.
  task automatic send(input logic we, input logic [14:0] a, input logic [7:0] d,
                      input int budget, output int waited);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    while (!req_ready && (waited < budget)) begin
      tick();
      waited++;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!rsp_valid && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_poll(input int budget, output int n);
    n = 0;
    while (ee_oe_n && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, lat, oec, pc, base, r0, idle;
    bit dqoe_seen;
    logic [14:0] e2_addr [3];
    logic [7:0]  e2_dat  [3];
    logic [14:0] e6_addr [4];
    logic [7:0]  e6_dat  [4];
    e2_addr = '{15'h0040, 15'h0041, 15'h007F};
    e2_dat  = '{8'h11, 8'h22, 8'h33};
    e6_addr = '{15'h5555, 15'h2AAA, 15'h5555, 15'h0100};
    e6_dat  = '{8'hAA, 8'h55, 8'hA0, 8'hA5};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    check("rst_strobes", {ee_ce_n, ee_oe_n, ee_we_n, ee_dq_oe}, 4'b1110);
    check("rst_handshake", {req_ready, rsp_valid, wr_err}, 3'b100);
    check("rst_addr", ee_addr, 0);
    check("rst_dq_o", ee_dq_o, 0);
    check("rst_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 1: single read of 0x1234
    send(1'b0, 15'h1234, 8'h00, 5, n);
    check("t1_accept_wait", n, 0);
    lat = 1;
    oec = 0;
    dqoe_seen = 1'b0;
    while (!rsp_valid && (lat < 20)) begin
      if (!ee_oe_n) oec++;
      if (ee_dq_oe) dqoe_seen = 1'b1;
      tick();
      lat++;
    end
    check("t1_latency", lat, 5);
    check("t1_oe_cycles", oec, 4);
    check("t1_rdata", rsp_rdata, 8'h5A);
    check("t1_rsp_strobes", {ee_ce_n, ee_oe_n}, 2'b11);
    check("t1_dq_oe", dqoe_seen, 1'b0);
    tick();
    check("t1_rsp_one_cycle", rsp_valid, 1'b0);

    // 2: three same-page writes, one page commit after 50 busy cycles
    base = log_n;
    r0   = rsp_cnt;
    send(1'b1, 15'h0040, 8'h11, 40, n);
    check("t2_accept1", n < 40, 1'b1);
    send(1'b1, 15'h0041, 8'h22, 40, n);
    check("t2_accept2", n < 40, 1'b1);
    send(1'b1, 15'h007F, 8'h33, 40, n);
    check("t2_accept3", n < 40, 1'b1);
    n = 0;
    idle = 0;
    while (ee_oe_n && (n < 1000)) begin
      if (ee_ce_n) idle++;
      tick();
      n++;
    end
    check("t2_idle_before_poll", idle, 100);
    check("t2_poll_addr", ee_addr, 15'h007F);
    busy_until = cyc + 50;
    wait_rsp(400, n);
    check("t2_rsp", rsp_valid, 1'b1);
    check("t2_wr_err", wr_err, 1'b0);
    repeat (20) tick();
    check("t2_rsp_count", rsp_cnt - r0, 1);
    check("t2_we_pulses", log_n - base, 3 + SDP_N);
    for (int i = 0; i < 3; i++) begin
      check("t2_we_addr", log_addr[base + SDP_N + i], e2_addr[i]);
      check("t2_we_data", log_dat[base + SDP_N + i], e2_dat[i]);
      check("t2_we_len", log_len[base + SDP_N + i], 3);
    end
    check("t2_rdata_held", rsp_rdata, 8'h5A);

    // 3: cross-page write stalls until page 0 commits
    r0 = rsp_cnt;
    send(1'b1, 15'h003F, 8'hC3, 40, n);
    send(1'b1, 15'h0040, 8'h44, 1000, n);
    check("t3_stalled", (n >= 100) && (n < 1000), 1'b1);
    check("t3_commit_first", rsp_cnt - r0, 1);
    wait_rsp(400, n);
    check("t3_rsp2", rsp_valid, 1'b1);
    check("t3_wr_err", wr_err, 1'b0);
    tick();
    check("t3_last_addr", log_addr[log_n - 1], 15'h0040);
    check("t3_last_data", log_dat[log_n - 1], 8'h44);

    // 4: device never finishes -> timeout, then next request clears wr_err
    busy_forever = 1'b1;
    send(1'b1, 15'h1000, 8'h80, 40, n);
    wait_poll(1000, n);
    check("t4_poll_start", ee_oe_n, 1'b0);
    pc = 0;
    while (!rsp_valid && (pc < 12000)) begin
      pc++;
      tick();
    end
    check("t4_poll_cycles", pc, 10000);
    check("t4_rsp", rsp_valid, 1'b1);
    check("t4_wr_err", wr_err, 1'b1);
    busy_forever = 1'b0;
    tick();
    check("t4_err_sticky", wr_err, 1'b1);
    send(1'b0, 15'h1234, 8'h00, 5, n);
    check("t4_err_clear", wr_err, 1'b0);
    wait_rsp(20, n);
    check("t4_read_rsp", rsp_valid, 1'b1);
    check("t4_read_data", rsp_rdata, 8'h5A);
    tick();

    // 5: reset during the WE# pulse
    send(1'b1, 15'h2000, 8'h12, 40, n);
    tick();
    check("t5_in_pulse", ee_we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_strobes", {ee_we_n, ee_dq_oe, ee_ce_n, ee_oe_n}, 4'b1011);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0  = rsp_cnt;
    oec = 0;
    repeat (200) begin
      if (!ee_oe_n) oec++;
      tick();
    end
    check("t5_no_rsp", rsp_cnt - r0, 0);
    check("t5_no_poll", oec, 0);
    check("t5_ready", req_ready, 1'b1);

`ifdef EE_SDP_EN
    // 6: unlock sequence precedes the host byte
    base = log_n;
    send(1'b1, 15'h0100, 8'hA5, 40, n);
    wait_poll(1000, n);
    check("t6_poll_addr", ee_addr, 15'h0100);
    wait_rsp(100, n);
    check("t6_rsp", rsp_valid, 1'b1);
    tick();
    check("t6_we_pulses", log_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("t6_we_addr", log_addr[base + i], e6_addr[i]);
      check("t6_we_data", log_dat[base + i], e6_dat[i]);
    end
`endif

    check("bus_rules", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
